wakeup_arbiter: RTL
===================

# wakeup_arbiter

- Shares two wakeup/broadcast ports among four result producers: functional units FU1–FU3 and the load-store queue.
- Holds each producer's result in a one-entry slot and grants up to two slots per cycle in round-robin order.
- Drives registered broadcasts that feed the Rename, ReservationStation, ReorderBuffer and LoadStoreQueue wakeup inputs.
- Producers see backpressure through per-requester ready signals, so no result is dropped when more than two complete at once.

## Interface

Parameters:
- DATA_W, 32, result value width
- TAG_W, 6, physical register tag width
- ROB_W, 6, ROB index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req_valid  in  4  bit i = requester i (0–2 = FU1–FU3, 3 = LSQ) presents a result
- req_tag  in  4*TAG_W  packed destination tags; requester i at [i*TAG_W +: TAG_W]
- req_rob  in  4*ROB_W  packed ROB indices, same packing
- req_value  in  4*DATA_W  packed values, same packing
- req_ready  out  4  bit i = slot i can accept this cycle
- bcast0_valid / bcast1_valid  out  1  broadcast port 0 / port 1 valid
- bcast0_tag / bcast1_tag  out  TAG_W  broadcast tag
- bcast0_rob / bcast1_rob  out  ROB_W  broadcast ROB index
- bcast0_value / bcast1_value  out  DATA_W  broadcast value
- pending  out  3  number of occupied slots, 0–4

## Operation

- **State:**
  - hold_valid[3:0] plus per-slot tag, rob and value.
  - rr_ptr[1:0].
  - Registered broadcast outputs.
- **Grant (combinational, from hold_valid and rr_ptr only):**
  - Scan slots rr_ptr, rr_ptr+1, … mod 4.
  - The first occupied slot is grant A and goes to port 0.
  - The second occupied slot is grant B and goes to port 1.
  - At most 2 grants per cycle.
- **req_ready[i]** = !hold_valid[i] || granted[i]. It must not depend on req_valid, so there is no combinational loop.
- **Accept:** when req_valid[i] && req_ready[i], slot i loads tag/rob/value at the edge and hold_valid[i] stays or becomes 1.
- **Granted slot not reloaded:** hold_valid[i] clears at the edge.
- **Broadcast registers, at each edge:**
  - bcast0_* load grant A's contents, or bcast0_valid=0 if there is no grant.
  - bcast1_* load grant B's contents, or bcast1_valid=0 if there is no second grant.
  - Data fields hold their last value when valid=0.
- **rr_ptr update:**
  - If there are any grants, rr_ptr <= (index of last granted slot + 1) mod 4.
  - Otherwise unchanged.
- **Port order:** port 0 always carries the earlier grant in scan order. Port 1 is never valid while port 0 is invalid.
- **pending** = popcount(hold_valid), registered state, not next-state.
- **Tag value 0** receives no special treatment; it is broadcast like any other tag.
- **Reset (asserted = 0):**
  - hold_valid=0, rr_ptr=0, both bcast valids=0, all data fields 0, pending=0.
  - req_ready=4'b1111 while reset is deasserted with empty slots.
  - Reset mid-operation discards all held results without broadcasting them.

## Timing

- **Latency:** a request accepted at edge E is broadcast at edge E+1 at the earliest, i.e. 2 cycles from the presentation cycle to the bcast valid cycle.
- **Throughput:**
  - Aggregate is 2 results/cycle.
  - A single requester can sustain 1 result/cycle when granted every cycle, because the slot is vacated and refilled at the same edge.
- **Fairness:** with all four slots continuously full, every slot is granted at least once every 2 cycles.
- **Simultaneous events:** grant and accept to the same slot at the same edge are legal and required (refill).
- **Outputs:** all outputs except req_ready are registered. req_ready is combinational from registered state only.

## Test plan

- **Single request:** after reset, requester 1 presents tag=5, rob=3, value=0x1234 in cycle 0 only.
  - Cycle 2: bcast0_valid=1 with those fields, bcast1_valid=0.
  - rr_ptr becomes 2.
  - pending=1 in cycle 1, 0 in cycle 2.
- **All four at once:** requesters 0–3 present tags 10–13 in cycle 0, with rr_ptr=0.
  - Cycle 2: port0 tag 10, port1 tag 11.
  - Cycle 3: port0 tag 12, port1 tag 13.
  - req_ready=4'b0011 in cycle 1; pending goes 4, 2, 0.
- **Round-robin rotation:** slots 0 and 3 continuously refilled, with rr_ptr=1.
  - First broadcast: port0=slot 3, port1=slot 0.
  - rr_ptr then becomes 1.
  - No slot starves over 20 cycles.
- **Back-to-back single requester:** requester 3 presents values 1, 2, 3, 4 in consecutive cycles 0–3.
  - req_ready[3] stays 1.
  - bcast0 shows 1, 2, 3, 4 in cycles 2–5.
- **Backpressure:** all four requesters hold req_valid=1 with changing values for 8 cycles.
  - No value is lost or duplicated.
  - Exactly 2 broadcasts per cycle once the slots are full.
  - req_ready never exceeds 2 bits set while pending=4.
- **Reset mid-operation:** with pending=3, drive reset=0 asynchronously between edges.
  - All valids and pending go to 0 immediately.
  - After release, req_ready=4'b1111 and no stale broadcast appears.

Source files
------------

// File: rtl/wakeup_arbiter_if.sv
// wakeup_arbiter_if
//   Groups the producer request/ready handshake and the two registered
//   wakeup broadcast ports of wakeup_arbiter.
//   slave  : arbiter side (takes requests, drives ready/broadcast/pending)
//   master : producer/consumer side (drives requests, observes the rest)
//   req_valid[4], req_tag/rob/value packed 4 ways, req_ready[4],
//   bcast0_*/bcast1_* (valid, tag, rob, value), pending[3].
interface wakeup_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6,
   parameter int ROB_W  = 6
);
   logic [3:0]          req_valid;
   logic [4*TAG_W-1:0]  req_tag;
   logic [4*ROB_W-1:0]  req_rob;
   logic [4*DATA_W-1:0] req_value;
   logic [3:0]          req_ready;
   logic                bcast0_valid;
   logic [TAG_W-1:0]    bcast0_tag;
   logic [ROB_W-1:0]    bcast0_rob;
   logic [DATA_W-1:0]   bcast0_value;
   logic                bcast1_valid;
   logic [TAG_W-1:0]    bcast1_tag;
   logic [ROB_W-1:0]    bcast1_rob;
   logic [DATA_W-1:0]   bcast1_value;
   logic [2:0]          pending;

   modport slave (
      input  req_valid, req_tag, req_rob, req_value,
      output req_ready,
      output bcast0_valid, bcast0_tag, bcast0_rob, bcast0_value,
      output bcast1_valid, bcast1_tag, bcast1_rob, bcast1_value,
      output pending
   );

   modport master (
      output req_valid, req_tag, req_rob, req_value,
      input  req_ready,
      input  bcast0_valid, bcast0_tag, bcast0_rob, bcast0_value,
      input  bcast1_valid, bcast1_tag, bcast1_rob, bcast1_value,
      input  pending
   );
endinterface

// File: rtl/wakeup_arbiter.sv
// wakeup_arbiter
//   Shares two registered wakeup broadcast ports among four result producers
//   (FU1..FU3 on slots 0..2, LSQ on slot 3). Each producer owns a one-entry
//   holding slot; up to two occupied slots are granted per cycle in
//   round-robin order starting at rr_ptr. A granted slot may be refilled at
//   the same edge it is vacated, so one producer can sustain 1 result/cycle.
//   Ports: clk, reset (async, active-low), bus (wakeup_arbiter_if.slave).
module wakeup_arbiter #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6,
   parameter int ROB_W  = 6
) (
   input logic             clk,
   input logic             reset,
   wakeup_arbiter_if.slave bus
);
   localparam int N = 4;

   logic [N-1:0]      hold_valid_q, hold_valid_d;
   logic [TAG_W-1:0]  tag_q [N];
   logic [ROB_W-1:0]  rob_q [N];
   logic [DATA_W-1:0] value_q [N];
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [2:0]        pending_q, pending_d;

   logic              b0_vld_q, b1_vld_q;
   logic [TAG_W-1:0]  b0_tag_q, b1_tag_q;
   logic [ROB_W-1:0]  b0_rob_q, b1_rob_q;
   logic [DATA_W-1:0] b0_value_q, b1_value_q;

   logic              gnt_a_vld, gnt_b_vld;
   logic [1:0]        gnt_a_idx, gnt_b_idx, scan_idx;
   logic [N-1:0]      granted, ready, accept;

   // Grant: scan from rr_ptr; first occupied slot -> port 0, second -> port 1.
   always_comb begin
      gnt_a_vld = 1'b0;
      gnt_b_vld = 1'b0;
      gnt_a_idx = 2'd0;
      gnt_b_idx = 2'd0;
      scan_idx  = 2'd0;
      for (int k = 0; k < N; k++) begin
         scan_idx = rr_ptr_q + 2'(k);
         if (hold_valid_q[scan_idx]) begin
            if (!gnt_a_vld) begin
               gnt_a_vld = 1'b1;
               gnt_a_idx = scan_idx;
            end else if (!gnt_b_vld) begin
               gnt_b_vld = 1'b1;
               gnt_b_idx = scan_idx;
            end
         end
      end
      granted = '0;
      if (gnt_a_vld) granted[gnt_a_idx] = 1'b1;
      if (gnt_b_vld) granted[gnt_b_idx] = 1'b1;
   end

   // Ready depends only on registered state, never on req_valid.
   assign ready        = ~hold_valid_q | granted;
   assign accept       = bus.req_valid & ready;
   assign hold_valid_d = accept | (hold_valid_q & ~granted);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_b_vld)      rr_ptr_d = gnt_b_idx + 2'd1;
      else if (gnt_a_vld) rr_ptr_d = gnt_a_idx + 2'd1;
      pending_d = 3'(hold_valid_d[0]) + 3'(hold_valid_d[1])
                + 3'(hold_valid_d[2]) + 3'(hold_valid_d[3]);
   end

   // Slot / pointer state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_valid_q <= '0;
         rr_ptr_q     <= 2'd0;
         pending_q    <= 3'd0;
         for (int i = 0; i < N; i++) begin
            tag_q[i]   <= '0;
            rob_q[i]   <= '0;
            value_q[i] <= '0;
         end
      end else begin
         hold_valid_q <= hold_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         pending_q    <= pending_d;
         for (int i = 0; i < N; i++) begin
            if (accept[i]) begin
               tag_q[i]   <= bus.req_tag[i*TAG_W +: TAG_W];
               rob_q[i]   <= bus.req_rob[i*ROB_W +: ROB_W];
               value_q[i] <= bus.req_value[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Broadcast registers; data fields keep their last value when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b0_vld_q   <= 1'b0;
         b0_tag_q   <= '0;
         b0_rob_q   <= '0;
         b0_value_q <= '0;
         b1_vld_q   <= 1'b0;
         b1_tag_q   <= '0;
         b1_rob_q   <= '0;
         b1_value_q <= '0;
      end else begin
         b0_vld_q <= gnt_a_vld;
         b1_vld_q <= gnt_b_vld;
         if (gnt_a_vld) begin
            b0_tag_q   <= tag_q[gnt_a_idx];
            b0_rob_q   <= rob_q[gnt_a_idx];
            b0_value_q <= value_q[gnt_a_idx];
         end
         if (gnt_b_vld) begin
            b1_tag_q   <= tag_q[gnt_b_idx];
            b1_rob_q   <= rob_q[gnt_b_idx];
            b1_value_q <= value_q[gnt_b_idx];
         end
      end
   end

   assign bus.req_ready    = ready;
   assign bus.pending      = pending_q;
   assign bus.bcast0_valid = b0_vld_q;
   assign bus.bcast0_tag   = b0_tag_q;
   assign bus.bcast0_rob   = b0_rob_q;
   assign bus.bcast0_value = b0_value_q;
   assign bus.bcast1_valid = b1_vld_q;
   assign bus.bcast1_tag   = b1_tag_q;
   assign bus.bcast1_rob   = b1_rob_q;
   assign bus.bcast1_value = b1_value_q;
endmodule
